autoref_scheduler: RTL and testbench

- Turns the auto-refresh configuration (enable, interval, tRFC) into timed refresh requests for the command issuer.
- Counts refresh intervals and accumulates owed refreshes as pending credits.
- Raises a request/acknowledge handshake toward the command issuer and, once a refresh is accepted, blocks other command issue for tRFC cycles.
- Sits between the refresh configuration registers and the DRAM command sequencer.

---
 rtl/autoref_scheduler.sv | 126 ++++++++++++
 tb/tb_autoref_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/autoref_scheduler.sv
// Auto-refresh scheduler: turns the refresh interval into pending credits and
// runs the REQ/ACK handshake plus the tRFC blocking window toward the issuer.
module autoref_scheduler #(
    parameter int unsigned CNT_W       = 28,
    parameter int unsigned MAX_PENDING = 8,
    parameter int unsigned URGENT_TH   = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             aref_en,
    input  logic [CNT_W-1:0] aref_interval,
    input  logic [CNT_W-1:0] trfc,
    input  logic             ref_ack,
    output logic             ref_req,
    output logic             ref_block,
    output logic             ref_urgent,
    output logic [3:0]       pending_cnt,
    output logic             overflow
);

    localparam int unsigned PEND_W = 4;
    localparam int unsigned EXT_W  = CNT_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        TRFC = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] int_cnt;
    logic [CNT_W-1:0] trfc_cnt;
    logic [CNT_W-1:0] trfc_l;

    logic [EXT_W-1:0] int_next_c;
    logic [EXT_W-1:0] trfc_next_c;
    logic             int_wrap_c;
    logic             trfc_done_c;
    logic             tick_c;
    logic             accept_c;

    // One extra bit keeps counter + 1 from wrapping at the top of the range.
    assign int_next_c  = {1'b0, int_cnt} + EXT_W'(1);
    assign trfc_next_c = {1'b0, trfc_cnt} + EXT_W'(1);
    assign int_wrap_c  = int_next_c >= {1'b0, aref_interval};
    assign trfc_done_c = trfc_next_c >= {1'b0, trfc_l};
    assign tick_c      = aref_en && int_wrap_c;
    assign accept_c    = (state == REQ) && ref_ack;

    assign ref_urgent  = pending_cnt >= PEND_W'(URGENT_TH);

    // Refresh interval counter.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            int_cnt <= '0;
        end else if (!aref_en || int_wrap_c) begin
            int_cnt <= '0;
        end else begin
            int_cnt <= int_next_c[CNT_W-1:0];
        end
    end

    // Owed-refresh credits; a tick with no room left is recorded as overflow.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pending_cnt <= '0;
            overflow    <= 1'b0;
        end else if (!aref_en) begin
            pending_cnt <= '0;
        end else if (tick_c && !accept_c) begin
            if (pending_cnt == PEND_W'(MAX_PENDING)) begin
                overflow <= 1'b1;
            end else begin
                pending_cnt <= pending_cnt + PEND_W'(1);
            end
        end else if (accept_c && !tick_c && (pending_cnt != '0)) begin
            pending_cnt <= pending_cnt - PEND_W'(1);
        end
    end

    // Handshake and tRFC window sequencing.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            ref_req   <= 1'b0;
            ref_block <= 1'b0;
            trfc_cnt  <= '0;
            trfc_l    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (aref_en && (pending_cnt != '0)) begin
                        state   <= REQ;
                        ref_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (ref_ack) begin
                        state     <= TRFC;
                        ref_req   <= 1'b0;
                        ref_block <= 1'b1;
                        trfc_l    <= trfc;
                        trfc_cnt  <= '0;
                    end else if (!aref_en) begin
                        state   <= IDLE;
                        ref_req <= 1'b0;
                    end
                end
                TRFC: begin
                    if (trfc_done_c) begin
                        state     <= IDLE;
                        ref_block <= 1'b0;
                    end else begin
                        trfc_cnt <= trfc_next_c[CNT_W-1:0];
                    end
                end
                default: begin
                    state     <= IDLE;
                    ref_req   <= 1'b0;
                    ref_block <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_autoref_scheduler.sv
// Bench for autoref_scheduler: per-cycle scoreboard fed by a reference model,
// plus directed timing checks and a randomized soak.
module tb_autoref_scheduler;

    localparam int MAXP = 8;
    localparam int URG  = 6;

    logic        clk;
    logic        rstn;
    logic        aref_en;
    logic [27:0] aref_interval;
    logic [27:0] trfc;
    logic        ref_ack;
    logic        ref_req;
    logic        ref_block;
    logic        ref_urgent;
    logic [3:0]  pending_cnt;
    logic        overflow;

    autoref_scheduler dut (
        .clk           (clk),
        .rstn          (rstn),
        .aref_en       (aref_en),
        .aref_interval (aref_interval),
        .trfc          (trfc),
        .ref_ack       (ref_ack),
        .ref_req       (ref_req),
        .ref_block     (ref_block),
        .ref_urgent    (ref_urgent),
        .pending_cnt   (pending_cnt),
        .overflow      (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       req;
        logic       blk;
        logic       urg;
        logic [3:0] pend;
        logic       ovf;
    } snap_t;

    snap_t exp_q[$];
    int    n_total = 0;
    int    n_pass  = 0;

    // Reference model: credits as a plain integer, the window as a countdown.
    int m_cnt = 0, m_pend = 0, m_blk = 0, m_age = 0;
    bit m_req = 0, m_ovf = 0;
    int ack_mode = 0;   // 0 never, 1 after m_age >= ack_dly, 2 random, 3 manual
    int ack_dly  = 0;

    function automatic void model_edge();
        int    per, n_cnt, n_pend, n_blk, n_age;
        bit    n_req, n_ovf, tick, acc;
        snap_t s;
        if (!rstn) begin
            m_cnt = 0; m_pend = 0; m_ovf = 0; m_req = 0; m_blk = 0; m_age = 0;
        end else begin
            per    = (aref_interval < 28'd2) ? 1 : int'(aref_interval);
            tick   = aref_en && (m_cnt >= per - 1);
            acc    = m_req && ref_ack;
            n_cnt  = (!aref_en || tick) ? 0 : m_cnt + 1;
            n_ovf  = m_ovf;
            if (!aref_en) n_pend = 0;
            else if (tick && !acc && m_pend == MAXP) begin
                n_pend = MAXP;
                n_ovf  = 1;
            end else n_pend = m_pend + int'(tick) - int'(acc);
            n_req = m_req;
            n_blk = m_blk;
            n_age = m_age + 1;
            if (m_blk > 0) n_blk = m_blk - 1;
            else if (m_req) begin
                if (ref_ack) begin
                    n_req = 0;
                    n_blk = (trfc == 28'd0) ? 1 : int'(trfc);
                end else if (!aref_en) n_req = 0;
            end else if (aref_en && m_pend > 0) begin
                n_req = 1;
                n_age = 0;
            end
            m_cnt = n_cnt; m_pend = n_pend; m_ovf = n_ovf;
            m_req = n_req; m_blk = n_blk; m_age = n_age;
        end
        s.req  = m_req;
        s.blk  = (m_blk > 0);
        s.urg  = (m_pend >= URG);
        s.pend = 4'(m_pend);
        s.ovf  = m_ovf;
        exp_q.push_back(s);
    endfunction

    // Monitor: every cycle's outputs are compared against the queued expectation.
    always @(negedge clk) begin
        snap_t a, e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {ref_req, ref_block, ref_urgent, pending_cnt, overflow};
            n_total++;
            if (a === e) n_pass++;
            else $display("FAIL cycle_outputs t=%0t got req=%b blk=%b urg=%b pend=%0d ovf=%b expected req=%b blk=%b urg=%b pend=%0d ovf=%b",
                          $time, a.req, a.blk, a.urg, a.pend, a.ovf, e.req, e.blk, e.urg, e.pend, e.ovf);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s got %0d expected %0d", name, act, exp);
    endtask

    task automatic drive_ack();
        case (ack_mode)
            0: ref_ack = 1'b0;
            1: ref_ack = m_req && (m_age >= ack_dly);
            2: ref_ack = ($urandom_range(0, 2) == 0);
            default: ;
        endcase
    endtask

    task automatic step();
        drive_ack();
        @(posedge clk);
        model_edge();
        #2;
    endtask

    task automatic do_reset();
        rstn = 1'b0; aref_en = 1'b0; ack_mode = 0;
        step();
        step();
        rstn = 1'b1;
    endtask

    task automatic wait_block(output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (ref_block) begin
                ok = 1;
                break;
            end
            step();
        end
    endtask

    task automatic count_block(output int len);
        len = 0;
        for (int i = 0; i < 100; i++) begin
            if (!ref_block) break;
            len++;
            step();
        end
    endtask

    initial begin
        int k;
        int len;
        bit ok;
        bit seen;
        rstn = 1'b0; aref_en = 1'b0; ref_ack = 1'b0;
        aref_interval = 28'd10; trfc = 28'd4;

        // Basic periodic refresh with a 2-cycle ack.
        do_reset();
        check("reset_req", int'(ref_req), 0);
        check("reset_pend", int'(pending_cnt), 0);
        aref_interval = 28'd10; trfc = 28'd4; ack_mode = 1; ack_dly = 2; aref_en = 1'b1;
        k = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            k++;
            if (ref_req) break;
        end
        check("first_req_delay", k, 11);
        for (int i = 0; i < 60; i++) step();
        aref_interval = 28'd1000;
        for (int i = 0; i < 30; i++) step();
        check("drained_pend", int'(pending_cnt), 0);

        // Starved issuer: saturation, urgency and overflow, then drain.
        do_reset();
        aref_interval = 28'd5; trfc = 28'd4; ack_mode = 0; aref_en = 1'b1;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (ref_urgent && !seen) begin
                seen = 1;
                check("urgent_threshold", int'(pending_cnt), URG);
            end
        end
        check("urgent_seen", int'(seen), 1);
        check("sat_pend", int'(pending_cnt), MAXP);
        check("sat_overflow", int'(overflow), 1);
        aref_interval = 28'd1000; ack_mode = 1; ack_dly = 0;
        for (int i = 0; i < 80; i++) step();
        check("drain_pend", int'(pending_cnt), 0);
        check("overflow_sticky", int'(overflow), 1);

        // Window length: trfc=0, then trfc changed mid-window.
        do_reset();
        aref_interval = 28'd8; trfc = 28'd0; ack_mode = 1; ack_dly = 1; aref_en = 1'b1;
        wait_block(ok);
        check("blk_seen_t0", int'(ok), 1);
        count_block(len);
        check("trfc0_len", len, 1);
        trfc = 28'd4;
        wait_block(ok);
        trfc = 28'd20;
        count_block(len);
        check("trfc_hold_len", len, 4);
        wait_block(ok);
        count_block(len);
        check("trfc_new_len", len, 20);

        // Enable dropped in REQ, then mid-window.
        do_reset();
        aref_interval = 28'd6; trfc = 28'd4; ack_mode = 0; aref_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (m_req) break;
            step();
        end
        aref_en = 1'b0;
        step();
        check("disable_req", int'(ref_req), 0);
        check("disable_pend", int'(pending_cnt), 0);
        aref_en = 1'b1; ack_mode = 1; ack_dly = 1;
        for (int i = 0; i < 60; i++) begin
            if (ref_block) break;
            step();
        end
        aref_en = 1'b0;
        count_block(len);
        check("disable_mid_window_len", len, 4);
        step();
        check("idle_after_window", int'(ref_req), 0);

        // Tick coincident with an accepted ack at pending_cnt = 3.
        do_reset();
        aref_interval = 28'd5; trfc = 28'd4; ack_mode = 0; aref_en = 1'b1;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (m_pend == 3 && m_cnt == 4 && m_req) begin
                ok = 1;
                break;
            end
        end
        check("tick_ack_setup", int'(ok), 1);
        ack_mode = 3; ref_ack = 1'b1;
        step();
        ref_ack = 1'b0; ack_mode = 0;
        check("tick_ack_pend", int'(pending_cnt), 3);

        // Reset in the middle of a window.
        do_reset();
        aref_interval = 28'd6; trfc = 28'd8; ack_mode = 1; ack_dly = 0; aref_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (ref_block) break;
            step();
        end
        step();
        step();
        rstn = 1'b0;
        step();
        check("rst_mid_block", int'(ref_block), 0);
        check("rst_mid_req", int'(ref_req), 0);
        check("rst_mid_pend", int'(pending_cnt), 0);
        rstn = 1'b1;
        k = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            k++;
            if (ref_req) break;
        end
        check("req_after_reset", k, 7);

        // Randomized soak against the model.
        ack_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            if (aref_en && $urandom_range(0, 59) == 0) aref_en = 1'b0;
            else if (!aref_en && $urandom_range(0, 7) == 0) aref_en = 1'b1;
            if ($urandom_range(0, 39) == 0) aref_interval = 28'($urandom_range(0, 12));
            if ($urandom_range(0, 29) == 0) trfc = 28'($urandom_range(0, 8));
            if ($urandom_range(0, 49) == 0) begin
                ack_mode = ($urandom_range(0, 1) == 0) ? 1 : 2;
                ack_dly  = $urandom_range(0, 3);
            end
            rstn = ($urandom_range(0, 499) != 0);
            step();
        end
        rstn = 1'b1;

        ack_mode = 0; aref_en = 1'b0;
        step();
        step();
        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
